// File: rtl/riscv_dmem_tcm.sv
// Data-memory responder for the core's dmem bus: word-addressed TCM with
// programmable wait states, byte-lane writes and misaligned/page-fault flags.
module riscv_dmem_tcm #(
  parameter int          XLEN    = 32,
  parameter int          DEPTH   = 1024,
  parameter int          LATENCY = 1,
  parameter logic [31:0] BASE    = 32'h0000_0000
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              dmem_req,
  input  logic [XLEN-1:0]   dmem_adr,
  input  logic [XLEN-1:0]   dmem_d,
  input  logic              dmem_we,
  input  logic [XLEN/8-1:0] dmem_be,
  output logic [XLEN-1:0]   dmem_q,
  output logic              dmem_ack,
  output logic              dmem_misaligned,
  output logic              dmem_page_fault
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = XLEN / 8;
  localparam logic [XLEN-1:0] BASE_W  = XLEN'(BASE);
  localparam logic [XLEN:0]   BASE_X  = (XLEN+1)'(BASE);
  localparam logic [XLEN:0]   LIMIT_X = BASE_X + ((XLEN+1)'(DEPTH) << 2);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [2:0]      cnt_q, cnt_d;
  logic [AW-1:0]   idx_q;
  logic [XLEN-1:0] wdat_q;
  logic            we_q;
  logic [NB-1:0]   be_q;
  logic            mis_q, pf_q;

  logic [XLEN-1:0] mem [DEPTH];

  logic [AW-1:0]   in_idx;
  logic            in_mis, in_pf;
  logic            accept, commit, use_in;
  logic [AW-1:0]   c_idx;
  logic [XLEN-1:0] c_dat;
  logic            c_we;
  logic [NB-1:0]   c_be;
  logic            c_fault;

  assign in_idx = AW'((dmem_adr - BASE_W) >> 2);
  assign in_pf  = ({1'b0, dmem_adr} < BASE_X) || ({1'b0, dmem_adr} >= LIMIT_X);

  always_comb begin
    in_mis = 1'b1;
    case (dmem_be)
      4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: in_mis = 1'b0;
      default:                   in_mis = 1'b1;
    endcase
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    commit  = 1'b0;
    use_in  = 1'b0;
    case (state_q)
      S_IDLE, S_ACK: begin
        if (dmem_req) begin
          accept = 1'b1;
          if (LATENCY == 0) begin
            state_d = S_ACK;
            commit  = 1'b1;
            use_in  = 1'b1;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 3'(LATENCY - 1);
          end
        end else begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 3'd0) begin
          state_d = S_ACK;
          commit  = 1'b1;
        end else begin
          cnt_d = cnt_q - 3'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // With zero wait states the transaction completes at its own acceptance edge,
  // so the commit path takes the live bus instead of the captured request.
  assign c_idx   = use_in ? in_idx   : idx_q;
  assign c_dat   = use_in ? dmem_d   : wdat_q;
  assign c_we    = use_in ? dmem_we  : we_q;
  assign c_be    = use_in ? dmem_be  : be_q;
  assign c_fault = use_in ? (in_mis | in_pf) : (mis_q | pf_q);

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_q <= S_IDLE;
      cnt_q   <= 3'd0;
      mis_q   <= 1'b0;
      pf_q    <= 1'b0;
      dmem_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        mis_q <= in_mis;
        pf_q  <= in_pf;
      end
      if (commit) begin
        if (c_fault)
          dmem_q <= '0;
        else if (!c_we)
          dmem_q <= mem[c_idx];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      idx_q  <= in_idx;
      wdat_q <= dmem_d;
      we_q   <= dmem_we;
      be_q   <= dmem_be;
    end
  end

  always_ff @(posedge clk) begin
    if (rstn && commit && c_we && !c_fault) begin
      for (int i = 0; i < NB; i++) begin
        if (c_be[i])
          mem[c_idx][i*8 +: 8] <= c_dat[i*8 +: 8];
      end
    end
  end

  assign dmem_ack        = (state_q == S_ACK);
  assign dmem_misaligned = dmem_ack & mis_q;
  assign dmem_page_fault = dmem_ack & pf_q;

endmodule

// File: tb/tb_riscv_dmem_tcm.sv
// Bench for riscv_dmem_tcm: four instances (LATENCY 1, 0, 3 and a small
// offset-BASE LATENCY 2 part) driven by directed tables and random traffic.
module tb_riscv_dmem_tcm;
  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  logic        req [4];
  logic        we  [4];
  logic [31:0] adr [4];
  logic [31:0] dat [4];
  logic [3:0]  be  [4];
  logic [31:0] q   [4];
  logic        ack [4];
  logic        mis [4];
  logic        pf  [4];

  int n_chk  = 0;
  int n_fail = 0;

  riscv_dmem_tcm #(.LATENCY(1)) u_lat1 (
    .clk(clk), .rstn(rstn), .dmem_req(req[0]), .dmem_adr(adr[0]), .dmem_d(dat[0]),
    .dmem_we(we[0]), .dmem_be(be[0]), .dmem_q(q[0]), .dmem_ack(ack[0]),
    .dmem_misaligned(mis[0]), .dmem_page_fault(pf[0]));

  riscv_dmem_tcm #(.LATENCY(0)) u_lat0 (
    .clk(clk), .rstn(rstn), .dmem_req(req[1]), .dmem_adr(adr[1]), .dmem_d(dat[1]),
    .dmem_we(we[1]), .dmem_be(be[1]), .dmem_q(q[1]), .dmem_ack(ack[1]),
    .dmem_misaligned(mis[1]), .dmem_page_fault(pf[1]));

  riscv_dmem_tcm #(.LATENCY(3)) u_lat3 (
    .clk(clk), .rstn(rstn), .dmem_req(req[2]), .dmem_adr(adr[2]), .dmem_d(dat[2]),
    .dmem_we(we[2]), .dmem_be(be[2]), .dmem_q(q[2]), .dmem_ack(ack[2]),
    .dmem_misaligned(mis[2]), .dmem_page_fault(pf[2]));

  riscv_dmem_tcm #(.DEPTH(64), .LATENCY(2), .BASE(32'h0000_4000)) u_rand (
    .clk(clk), .rstn(rstn), .dmem_req(req[3]), .dmem_adr(adr[3]), .dmem_d(dat[3]),
    .dmem_we(we[3]), .dmem_be(be[3]), .dmem_q(q[3]), .dmem_ack(ack[3]),
    .dmem_misaligned(mis[3]), .dmem_page_fault(pf[3]));

  typedef struct packed {
    logic        w;
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  b;
    logic [31:0] eq;
    logic        emis;
    logic        epf;
  } vec_t;

  vec_t        tbl [14];
  logic [3:0]  legal_be [7] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111};
  logic        s_w [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  logic [31:0] s_a [6] = '{32'h0, 32'h4, 32'h0, 32'h4, 32'h8, 32'h8};
  logic [31:0] s_d [6] = '{32'h1, 32'h2, 32'h0, 32'h0, 32'h3, 32'h0};
  logic [31:0] s_q [6] = '{32'h0, 32'h0, 32'h1, 32'h2, 32'h2, 32'h3};

  logic [31:0] mm [64];
  logic [31:0] qm;
  logic [31:0] rq, ra, rd;
  logic        rmis, rpf, rw, e_mis, e_pf;
  logic [3:0]  rb;
  int          lat, acks, got_at, idx;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Issue one request at the current negedge and wait (bounded) for its ack.
  task automatic txn(input int k, input logic w, input logic [31:0] a, input logic [31:0] d,
                     input logic [3:0] b, output logic [31:0] oq, output logic omis,
                     output logic opf, output int olat);
    int stray = 0;
    req[k] = 1'b1; we[k] = w; adr[k] = a; dat[k] = d; be[k] = b;
    olat = -1; oq = '0; omis = 1'b0; opf = 1'b0;
    for (int i = 1; i <= 20 && olat < 0; i++) begin
      @(negedge clk);
      if (ack[k]) begin
        olat = i; oq = q[k]; omis = mis[k]; opf = pf[k];
      end else if (mis[k] || pf[k]) begin
        stray++;
      end
      req[k] = 1'b0;
    end
    req[k] = 1'b0;
    chk("stray_flags", stray, 0);
    $display("txn inst%0d we=%0b adr=%h d=%h be=%b -> lat=%0d q=%h mis=%0b pf=%0b",
             k, w, a, d, b, olat, oq, omis, opf);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{1'b1, 32'h10,       32'hDEADBEEF, 4'b1111, 32'h0,        1'b0, 1'b0};
    tbl[1]  = '{1'b0, 32'h10,       32'h0,        4'b1111, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[2]  = '{1'b1, 32'h12,       32'h00AA0000, 4'b0100, 32'hDEADBEEF, 1'b0, 1'b0};
    tbl[3]  = '{1'b0, 32'h10,       32'h0,        4'b1111, 32'hDEAABEEF, 1'b0, 1'b0};
    tbl[4]  = '{1'b1, 32'h10,       32'h12340000, 4'b1100, 32'hDEAABEEF, 1'b0, 1'b0};
    tbl[5]  = '{1'b0, 32'h10,       32'h0,        4'b1111, 32'h1234BEEF, 1'b0, 1'b0};
    tbl[6]  = '{1'b1, 32'h10,       32'hFFFFFFFF, 4'b0110, 32'h0,        1'b1, 1'b0};
    tbl[7]  = '{1'b0, 32'h10,       32'h0,        4'b1111, 32'h1234BEEF, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 32'h1000,     32'h0,        4'b1111, 32'h0,        1'b0, 1'b1};
    tbl[9]  = '{1'b0, 32'h10,       32'h0,        4'b0000, 32'h0,        1'b1, 1'b0};
    tbl[10] = '{1'b0, 32'hFFFFFFFC, 32'h0,        4'b0101, 32'h0,        1'b1, 1'b1};
    tbl[11] = '{1'b0, 32'h13,       32'h0,        4'b1000, 32'h1234BEEF, 1'b0, 1'b0};
    tbl[12] = '{1'b1, 32'hFFC,      32'hAABBCCDD, 4'b1111, 32'h1234BEEF, 1'b0, 1'b0};
    tbl[13] = '{1'b0, 32'hFFC,      32'h0,        4'b1111, 32'hAABBCCDD, 1'b0, 1'b0};

    rstn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      req[k] = 1'b0; we[k] = 1'b0; adr[k] = '0; dat[k] = '0; be[k] = '0;
    end
    repeat (3) @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("reset_ack%0d", k), 32'(ack[k]), 0);
      chk($sformatf("reset_mis%0d", k), 32'(mis[k]), 0);
      chk($sformatf("reset_pf%0d", k),  32'(pf[k]), 0);
      chk($sformatf("reset_q%0d", k),   q[k], 0);
    end
    rstn = 1'b1;
    @(negedge clk);

    // Directed vectors, one wait state.
    for (int i = 0; i < 14; i++) begin
      txn(0, tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].b, rq, rmis, rpf, lat);
      chk($sformatf("tbl%0d_lat", i), lat, 2);
      chk($sformatf("tbl%0d_q", i), rq, tbl[i].eq);
      chk($sformatf("tbl%0d_mis", i), 32'(rmis), 32'(tbl[i].emis));
      chk($sformatf("tbl%0d_pf", i), 32'(rpf), 32'(tbl[i].epf));
    end

    // Zero wait states: one request per cycle, each issued in the previous ack cycle.
    for (int i = 0; i < 6; i++) begin
      req[1] = 1'b1; we[1] = s_w[i]; adr[1] = s_a[i]; dat[1] = s_d[i]; be[1] = 4'hF;
      @(negedge clk);
      chk($sformatf("stream%0d_ack", i), 32'(ack[1]), 1);
      chk($sformatf("stream%0d_q", i), q[1], s_q[i]);
      $display("stream op%0d we=%0b adr=%h -> ack=%0b q=%h", i, s_w[i], s_a[i], ack[1], q[1]);
    end
    req[1] = 1'b0;
    @(negedge clk);
    chk("stream_idle_ack", 32'(ack[1]), 0);

    // Three wait states, with a stray request pulse during WAIT.
    txn(2, 1'b1, 32'h40, 32'h77, 4'hF, rq, rmis, rpf, lat);
    chk("lat3_wr_lat", lat, 4);
    req[2] = 1'b1; we[2] = 1'b0; adr[2] = 32'h40; be[2] = 4'hF;
    acks = 0; got_at = -1; rq = '0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ack[2]) begin
        acks++;
        if (got_at < 0) begin got_at = i; rq = q[2]; end
      end
      req[2] = (i == 2);
      if (i == 2) begin we[2] = 1'b1; dat[2] = 32'hBAD; end
    end
    we[2] = 1'b0;
    chk("lat3_ack_at", got_at, 4);
    chk("lat3_ack_count", acks, 1);
    chk("lat3_q", rq, 32'h77);
    txn(2, 1'b0, 32'h40, 32'h0, 4'hF, rq, rmis, rpf, lat);
    chk("lat3_ignored_wr_q", rq, 32'h77);

    // Random traffic against a word-array model; offset BASE, 64 words.
    qm = '0;
    for (int i = 0; i < 64; i++) begin
      rd = $urandom;
      txn(3, 1'b1, 32'h4000 + 32'(4 * i), rd, 4'hF, rq, rmis, rpf, lat);
      mm[i] = rd;
      chk("rinit_lat", lat, 3);
    end
    for (int n = 0; n < 300; n++) begin
      rw = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       ra = 32'h4000 - 32'(4 * $urandom_range(1, 4));
        1:       ra = 32'h4100 + 32'(4 * $urandom_range(0, 4));
        2:       ra = $urandom;
        default: ra = 32'h4000 + 32'($urandom_range(0, 255));
      endcase
      rb = ($urandom_range(0, 3) == 0) ? 4'($urandom) : legal_be[$urandom_range(0, 6)];
      rd = $urandom;
      e_mis = !(rb inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
      e_pf  = (ra < 32'h4000) || (ra >= 32'h4100);
      idx   = int'(((ra - 32'h4000) >> 2) & 32'h3F);
      if (e_mis || e_pf) begin
        qm = '0;
      end else if (rw) begin
        for (int l = 0; l < 4; l++)
          if (rb[l]) mm[idx][8*l +: 8] = rd[8*l +: 8];
      end else begin
        qm = mm[idx];
      end
      txn(3, rw, ra, rd, rb, rq, rmis, rpf, lat);
      chk($sformatf("rand%0d_lat", n), lat, 3);
      chk($sformatf("rand%0d_q", n), rq, qm);
      chk($sformatf("rand%0d_mis", n), 32'(rmis), 32'(e_mis));
      chk($sformatf("rand%0d_pf", n), 32'(rpf), 32'(e_pf));
    end

    // Reset while a write is waiting: no ack, write discarded.
    txn(2, 1'b1, 32'h20, 32'h11, 4'hF, rq, rmis, rpf, lat);
    chk("midrst_prep_lat", lat, 4);
    req[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h20; dat[2] = 32'h55; be[2] = 4'hF;
    acks = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (ack[2]) acks++;
      if (i == 1) req[2] = 1'b0;
      rstn = !(i == 2);
    end
    chk("midrst_acks", acks, 0);
    chk("midrst_q_reset", q[2], 0);
    txn(2, 1'b0, 32'h20, 32'h0, 4'hF, rq, rmis, rpf, lat);
    chk("midrst_rd_lat", lat, 4);
    chk("midrst_rd_q", rq, 32'h11);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
